clkdll_phase_gen: RTL

- Parametrised, synthesisable successor to the behavioural clock DLL primitive in the unisims library.
- Runs from a single clock, CLKIN. Produces NUM_PHASES evenly spaced divided-clock phases plus a CLKDV tap, all at a runtime-selectable integer divide.
- LOCKED asserts after a programmable settle interval. Any change to the divide forces a relock.
- Sits in the clocking library as the simulation and synthesis model for clock-enable and phase generation.

---
 rtl/clkdll_pkg.sv | 28 ++
 rtl/clkdll_phase_cmp.sv | 39 +++
 rtl/clkdll_phase_gen.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/clkdll_pkg.sv
// Shared definitions for the clock DLL phase generator: FSM encodings and
// the divide clamp / phase offset helpers used at elaboration and run time.
package clkdll_pkg;

  // FSM encodings, kept as plain constants so legacy tools read them unchanged
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOCKING = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  typedef logic [1:0] clkdll_state_t;

  // Divides of 0 and 1 cannot produce a clock; both are forced up to 2.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < 32'd2) ? 32'd2 : div;
  endfunction

  // Start offset of phase k for divide d: (k*d) / num_phases.
  // num_phases is a power of two, so the divide is a shift; k is a constant
  // at every call site, so the multiply reduces to shifts and adds.
  function automatic logic [31:0] phase_offset(input int unsigned k,
                                               input logic [31:0] d,
                                               input int unsigned num_phases);
    logic [63:0] prod;
    prod = 64'(k) * 64'(d);
    return 32'(prod >> $clog2(num_phases));
  endfunction

endpackage

// File: rtl/clkdll_phase_cmp.sv
// One registered phase tap: high while the count, taken relative to this
// tap's offset, is inside the high window of the current period.
module clkdll_phase_cmp
  import clkdll_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] off,
  input  logic [W-1:0] d,
  input  logic [W-1:0] h,
  output logic         phase
);

  logic [W:0] diff_raw;
  logic [W:0] diff_mod;
  logic       phase_d;
  logic       phase_q;

  // (cnt - off) mod d without a divider: cnt and off are both below d, so a
  // single conditional add of d folds a negative difference back into range.
  always_comb begin
    diff_raw = {1'b0, cnt} - {1'b0, off};
    diff_mod = diff_raw[W] ? (diff_raw + {1'b0, d}) : diff_raw;
    phase_d  = run && (diff_mod < {1'b0, h});
  end

  // Output register; cleared asynchronously so the tap is low out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= 1'b0;
    else        phase_q <= phase_d;
  end

  assign phase = phase_q;

endmodule

// File: rtl/clkdll_phase_gen.sv
// Clock DLL phase generator: divides CLKIN by a runtime value into
// NUM_PHASES evenly spaced phases, mirrors one on CLKDV, and reports LOCKED
// after LOCK_PERIODS full output periods at a stable divide.
module clkdll_phase_gen
  import clkdll_pkg::*;
#(
  parameter int unsigned NUM_PHASES            = 4,
  parameter int unsigned DIV_WIDTH             = 8,
  parameter int unsigned LOCK_PERIODS          = 4,
  parameter string       DUTY_CYCLE_CORRECTION = "TRUE",
  parameter int unsigned CLKDV_PHASE           = 0
) (
  input  logic                  CLKIN,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic [DIV_WIDTH-1:0]  DIV,
  output logic [NUM_PHASES-1:0] PHASE,
  output logic                  CLKDV,
  output logic                  LOCKED,
  output logic [DIV_WIDTH-1:0]  DIV_ACT
);

  localparam bit          DUTY_ON  = (DUTY_CYCLE_CORRECTION == "TRUE");
  localparam logic [7:0]  LOCK_LIM = 8'(LOCK_PERIODS);

  clkdll_state_t        state_q,   state_d;
  logic [DIV_WIDTH-1:0] cnt_q,     cnt_d;
  logic [7:0]           per_cnt_q, per_cnt_d;
  logic [DIV_WIDTH-1:0] div_act_q, div_act_d;
  logic [DIV_WIDTH-1:0] div_raw_q, div_raw_d;
  logic                 locked_q,  locked_d;

  logic [DIV_WIDTH-1:0] div_clamped;
  logic [DIV_WIDTH-1:0] half_d;
  logic [DIV_WIDTH-1:0] high_len;
  logic [DIV_WIDTH-1:0] cnt_inc;
  logic [7:0]           per_inc;
  logic                 wrap;
  logic                 div_chg;
  logic                 run;

  // Per-cycle helpers: clamped request, high-window length, wrap and change
  // detection, and whether the phase taps are allowed to toggle this edge.
  always_comb begin
    div_clamped = DIV_WIDTH'(clamp_div(32'(DIV)));
    half_d      = div_act_q >> 1;
    high_len    = (DUTY_ON && (half_d > DIV_WIDTH'(1))) ? half_d : DIV_WIDTH'(1);
    wrap        = (cnt_q == (div_act_q - DIV_WIDTH'(1)));
    cnt_inc     = wrap ? '0 : (cnt_q + DIV_WIDTH'(1));
    per_inc     = (per_cnt_q == LOCK_LIM) ? per_cnt_q : (per_cnt_q + 8'd1);
    // The raw register is compared, so 0 -> 1 is a change even though both
    // clamp to the same divide.
    div_chg     = (DIV != div_raw_q);
    run         = EN && (state_q != ST_IDLE);
  end

  // Lock FSM and period counters. Priority inside a running state:
  // EN low, then a divide change at the wrap, then normal counting.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    per_cnt_d = per_cnt_q;
    div_act_d = div_act_q;
    div_raw_d = div_raw_q;
    locked_d  = locked_q;
    case (state_q)
      ST_IDLE: begin
        locked_d = 1'b0;
        if (EN) begin
          div_act_d = div_clamped;
          div_raw_d = DIV;
          cnt_d     = '0;
          per_cnt_d = '0;
          state_d   = ST_LOCKING;
        end
      end
      ST_LOCKING, ST_LOCKED: begin
        if (!EN) begin
          state_d   = ST_IDLE;
          locked_d  = 1'b0;
          cnt_d     = '0;
          per_cnt_d = '0;
        end else if (wrap && div_chg) begin
          // New divide only at a period boundary so no runt pulse escapes.
          div_act_d = div_clamped;
          div_raw_d = DIV;
          cnt_d     = '0;
          per_cnt_d = '0;
          locked_d  = 1'b0;
          state_d   = ST_LOCKING;
        end else begin
          cnt_d = cnt_inc;
          if (wrap) per_cnt_d = per_inc;
          if (state_q == ST_LOCKING) begin
            locked_d = 1'b0;
            if (wrap && (per_inc == LOCK_LIM)) state_d = ST_LOCKED;
          end else begin
            // LOCKED output trails the state by one edge.
            locked_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        locked_d = 1'b0;
      end
    endcase
  end

  // Control and counter registers, all cleared asynchronously.
  always_ff @(posedge CLKIN or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      per_cnt_q <= '0;
      div_act_q <= DIV_WIDTH'(2);
      div_raw_q <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_cnt_q <= per_cnt_d;
      div_act_q <= div_act_d;
      div_raw_q <= div_raw_d;
      locked_q  <= locked_d;
    end
  end

  for (genvar k = 0; k < NUM_PHASES; k++) begin : g_phase
    logic [DIV_WIDTH-1:0] off_k;

    assign off_k = DIV_WIDTH'(phase_offset(k, 32'(div_act_q), NUM_PHASES));

    clkdll_phase_cmp #(
      .W (DIV_WIDTH)
    ) u_cmp (
      .clk   (CLKIN),
      .rst_n (RST_N),
      .run   (run),
      .cnt   (cnt_q),
      .off   (off_k),
      .d     (div_act_q),
      .h     (high_len),
      .phase (PHASE[k])
    );
  end

  assign CLKDV   = PHASE[CLKDV_PHASE];
  assign LOCKED  = locked_q;
  assign DIV_ACT = div_act_q;

endmodule
